// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry in-order prefetch
// queue and a pipelined instruction-memory read port (up to MAX_OUT reads
// in flight). A redirect flushes the queue, reloads the fetch pc and marks
// every still-outstanding read for discard.
//
// Handshakes:
//   memory request : a read transfers on a rising clk_i when
//                    im_req_o && !im_busy_i. im_addr_o is stable while
//                    im_req_o is high and the memory is busy.
//   memory response: im_rvalid_i carries one word per cycle, in request
//                    order. There is no backpressure. The credit rule
//                    (count + pending < DEPTH) reserves a queue slot for
//                    every outstanding read.
//   decode         : the head transfers on a rising clk_i when
//                    valid_o && !stall_i.
module fetch_queue #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      MAX_OUT  = 2,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [XLEN-1:0]  NOP      = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            im_req_o,
  output logic [XLEN-1:0] im_addr_o,
  input  logic            im_busy_i,
  input  logic            im_rvalid_i,
  input  logic [XLEN-1:0] im_dout_i,
  output logic            valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            stall_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1);

  // Fetch bookkeeping.
  logic [XLEN-1:0]  r_fetch_pc;
  logic [OUT_W-1:0] r_pending;
  logic [OUT_W-1:0] r_drop;

  // Queue storage and pointers.
  logic [XLEN-1:0]  r_q_inst [DEPTH];
  logic [XLEN-1:0]  r_q_pc   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Combinational control.
  logic [SUM_W-1:0] w_occupancy;
  logic             w_req;
  logic             w_accept;
  logic             w_rsp;
  logic             w_drop_rsp;
  logic             w_enq;
  logic             w_valid;
  logic             w_deq;
  logic [XLEN-1:0]  w_rsp_pc;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_unused_bits;

  // The low two bits of the redirect target are forced to zero.
  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_bits = ^redirect_pc_i[1:0];

  // Credit rule: queued entries plus reads in flight never exceed DEPTH.
  // This guarantees that a response always finds a free queue slot.
  assign w_occupancy = SUM_W'(r_count) + SUM_W'(r_pending);
  assign w_req       = !redirect_i
                       && (r_pending < OUT_W'(MAX_OUT))
                       && (w_occupancy < SUM_W'(DEPTH));
  assign w_accept    = w_req && !im_busy_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp       = im_rvalid_i && (r_pending != '0);
  assign w_drop_rsp  = w_rsp && (r_drop != '0);
  assign w_enq       = w_rsp && !w_drop_rsp && !redirect_i;

  assign w_valid     = (r_count != '0);
  assign w_deq       = w_valid && !stall_i && !redirect_i;

  // Reads still in flight that are not being dropped form a contiguous run
  // of word addresses ending just below fetch_pc. The oldest of them, which
  // is the one answered now, therefore sits pending words back.
  assign w_rsp_pc    = r_fetch_pc - (XLEN'(r_pending) << 2);

  assign im_req_o    = w_req;
  assign im_addr_o   = r_fetch_pc;

  // Decode-side outputs come only from registered queue state.
  assign valid_o     = w_valid;
  assign inst_o      = w_valid ? r_q_inst[r_head] : NOP;
  assign pc_o        = w_valid ? r_q_pc[r_head]   : '0;
  assign stall_o     = !w_valid;

  // Fetch pc: reload on redirect, otherwise advance one word per accepted read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc <= w_redirect_pc;
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  // Outstanding-read counter: up on accept, down on any response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, w_rsp})
        2'b10:   r_pending <= r_pending + OUT_W'(1);
        2'b01:   r_pending <= r_pending - OUT_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Discard counter: a redirect condemns every read left in flight after this cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_drop <= '0;
    end else if (redirect_i) begin
      r_drop <= r_pending - OUT_W'(w_rsp);
    end else if (w_drop_rsp) begin
      r_drop <= r_drop - OUT_W'(1);
    end
  end

  // Queue pointers and occupancy. A redirect empties the queue.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: write the returning word and its address at the tail.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_q_inst[r_tail] <= im_dout_i;
      r_q_pc[r_tail]   <= w_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus for fetch_queue. A
// queue-based reference model predicts every output in every cycle.
module tb_fetch_queue;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic            clk;
  logic            rst_n_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            stall_i;
  logic            im_req_o;
  logic [XLEN-1:0] im_addr_o;
  logic            im_busy_i;
  logic            im_rvalid_i;
  logic [XLEN-1:0] im_dout_i;
  logic            valid_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] pc_o;
  logic            stall_o;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .im_req_o      (im_req_o),
    .im_addr_o     (im_addr_o),
    .im_busy_i     (im_busy_i),
    .im_rvalid_i   (im_rvalid_i),
    .im_dout_i     (im_dout_i),
    .valid_o       (valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .stall_o       (stall_o)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each outstanding read remembers its address and
  // whether a redirect has condemned it. exp_q holds the instructions that
  // decode should see, as {inst, pc}.
  typedef struct {
    logic [31:0] pc;
    bit          dead;
  } req_t;

  req_t        m_inflight[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc;

  // Memory model: addresses accepted by memory and not yet answered.
  logic [31:0] mem_q[$];
  logic [31:0] data_mask;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hold reset for n cycles, checking the reset outputs, then release just after a rising edge.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stall_i       = 1'b0;
    im_busy_i     = 1'b0;
    im_rvalid_i   = 1'b0;
    im_dout_i     = '0;
    mem_q.delete();
    m_inflight.delete();
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_valid", 32'(valid_o), 32'd0);
      check_eq("rst_inst",  inst_o,        NOP);
      check_eq("rst_pc",    pc_o,          32'd0);
      check_eq("rst_stall", 32'(stall_o), 32'd1);
      check_eq("rst_addr",  im_addr_o,     RESET_PC);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    rst_n_i = 1'b1;
  endtask

  // One cycle: drive inputs at the falling edge, check outputs against the model, then advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit stall,
                      input bit busy, input bit rsp_en);
    bit          rsp;
    bit          e_req;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] addr;
    logic [31:0] data;
    req_t        r;

    @(negedge clk);
    rsp = rsp_en && (mem_q.size() > 0);
    if (rsp) begin
      addr = mem_q.pop_front();
      data = addr ^ data_mask;
    end else begin
      data = $urandom;
    end
    redirect_i    = redir;
    redirect_pc_i = rpc;
    stall_i       = stall;
    im_busy_i     = busy;
    im_rvalid_i   = rsp;
    im_dout_i     = data;
    #1;

    e_req   = !redir && (m_inflight.size() < MAX_OUT)
              && (exp_q.size() + m_inflight.size() < DEPTH);
    e_valid = (exp_q.size() > 0);
    e_pc    = e_valid ? exp_q[0][31:0]  : 32'd0;
    e_inst  = e_valid ? exp_q[0][63:32] : NOP;

    check_eq("im_req",  32'(im_req_o), 32'(e_req));
    check_eq("im_addr", im_addr_o,     m_fetch_pc);
    check_eq("valid",   32'(valid_o),  32'(e_valid));
    check_eq("pc",      pc_o,          e_pc);
    check_eq("inst",    inst_o,        e_inst);
    check_eq("stall_o", 32'(stall_o),  32'(!e_valid));
    if (rsp) begin
      // A response must only ever answer an outstanding read.
      check_eq("rsp_outstanding", 32'(m_inflight.size() > 0), 32'd1);
    end

    // Memory records what it actually accepted this cycle.
    if (im_req_o && !busy) begin
      mem_q.push_back(im_addr_o);
    end

    // Advance the model.
    if (redir) begin
      if (rsp && m_inflight.size() > 0) begin
        r = m_inflight.pop_front();
      end
      foreach (m_inflight[i]) m_inflight[i].dead = 1'b1;
      exp_q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (e_valid && !stall) begin
        void'(exp_q.pop_front());
      end
      if (rsp && m_inflight.size() > 0) begin
        r = m_inflight.pop_front();
        if (!r.dead) exp_q.push_back({data, r.pc});
      end
      if (e_req && !busy) begin
        m_inflight.push_back('{pc: m_fetch_pc, dead: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    data_mask     = 32'h0;
    rst_n_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stall_i       = 1'b0;
    im_busy_i     = 1'b0;
    im_rvalid_i   = 1'b0;
    im_dout_i     = '0;
    m_fetch_pc    = RESET_PC;

    do_reset(3);

    // Ideal memory, data equals address: first valid at cycle 2, then one per cycle.
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Decode stalls long enough to fill the queue, then drains back-to-back.
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    repeat (8)  step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Memory busy for three cycles.
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Two reads left outstanding, then redirect to 0x100.
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Redirect coinciding with stall and a response; 0x103 fetches 0x100.
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h103, 1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Address wrap from the top word of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with scrambled data, a mid-run reset, then more traffic.
    data_mask = 32'h5A5A_C3C3;
    random_steps(400);
    do_reset(2);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    random_steps(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
